// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and constants for the serial bus arbiter
package bus_arb_pkg;

    localparam int NUM_INIT_DEF = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_SPLIT = 2'd2
    } arb_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - request/grant and split handshake bundle around the arbiter
interface bus_arbiter_if
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = NUM_INIT_DEF,
    parameter int IDX_W    = idx_width(NUM_INIT)
);

    logic [NUM_INIT-1:0] init_req;
    logic [NUM_INIT-1:0] init_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic                bus_busy;
    logic                target_ack;
    logic                target_split_ack;
    logic                split_req;
    logic                split_grant;
    logic                split_pending;
    logic [IDX_W-1:0]    split_owner;
    logic                split_err;

    modport master (
        input  init_req, target_ack, target_split_ack, split_req,
        output init_grant, grant_idx, bus_busy, split_grant,
               split_pending, split_owner, split_err
    );

    modport slave (
        output init_req, target_ack, target_split_ack, split_req,
        input  init_grant, grant_idx, bus_busy, split_grant,
               split_pending, split_owner, split_err
    );

endinterface

// File: rtl/bus_arb_rr_pick.sv
// rtl/bus_arb_rr_pick.sv - combinational round-robin picker starting after last_winner
module bus_arb_rr_pick
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = NUM_INIT_DEF,
    parameter int IDX_W    = idx_width(NUM_INIT)
) (
    input  logic [NUM_INIT-1:0] req,
    input  logic [NUM_INIT-1:0] mask,
    input  logic [IDX_W-1:0]    last_winner,
    output logic [NUM_INIT-1:0] winner,
    output logic [IDX_W-1:0]    winner_idx,
    output logic                any_valid
);

    always_comb begin
        int j;
        j          = 0;
        winner     = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        // last_winner itself is visited last, giving it the lowest priority
        for (int i = 1; i <= NUM_INIT; i++) begin
            j = (int'(last_winner) + i) % NUM_INIT;
            if (!any_valid && req[j] && !mask[j]) begin
                any_valid  = 1'b1;
                winner[j]  = 1'b1;
                winner_idx = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin bus arbiter with one parked split transaction
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int NUM_INIT = NUM_INIT_DEF,
    parameter int IDX_W    = idx_width(NUM_INIT)
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter_if.master bus
);

    arb_state_t          state;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    last_winner;
    logic [IDX_W-1:0]    ptr_next;
    logic [NUM_INIT-1:0] mask;
    logic [NUM_INIT-1:0] pick_onehot;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_valid;

    // rr_ptr is the next index to favour, so a freshly reset bus starts at 0
    assign last_winner = (rr_ptr == '0) ? IDX_W'(NUM_INIT - 1) : rr_ptr - 1'b1;
    assign ptr_next    = (bus.grant_idx == IDX_W'(NUM_INIT - 1)) ? '0 : bus.grant_idx + 1'b1;

    always_comb begin
        mask = '0;
        if (bus.split_pending) mask[bus.split_owner] = 1'b1;
    end

    bus_arb_rr_pick #(
        .NUM_INIT (NUM_INIT),
        .IDX_W    (IDX_W)
    ) u_rr_pick (
        .req         (bus.init_req),
        .mask        (mask),
        .last_winner (last_winner),
        .winner      (pick_onehot),
        .winner_idx  (pick_idx),
        .any_valid   (pick_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ARB_IDLE;
            rr_ptr            <= '0;
            bus.init_grant    <= '0;
            bus.grant_idx     <= '0;
            bus.bus_busy      <= 1'b0;
            bus.split_grant   <= 1'b0;
            bus.split_pending <= 1'b0;
            bus.split_owner   <= '0;
            bus.split_err     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (bus.split_pending && bus.split_req) begin
                        state           <= ARB_SPLIT;
                        bus.split_grant <= 1'b1;
                        bus.init_grant  <= NUM_INIT'(1) << bus.split_owner;
                        bus.grant_idx   <= bus.split_owner;
                        bus.bus_busy    <= 1'b1;
                    end else if (pick_valid) begin
                        state          <= ARB_BUSY;
                        bus.init_grant <= pick_onehot;
                        bus.grant_idx  <= pick_idx;
                        bus.bus_busy   <= 1'b1;
                    end
                end
                ARB_BUSY: begin
                    if (bus.target_ack) begin
                        state          <= ARB_IDLE;
                        bus.init_grant <= '0;
                        bus.bus_busy   <= 1'b0;
                        rr_ptr         <= ptr_next;
                    end else if (bus.target_split_ack) begin
                        state          <= ARB_IDLE;
                        bus.init_grant <= '0;
                        bus.bus_busy   <= 1'b0;
                        // only one transaction can be parked; a second split is an error and ends normally
                        if (!bus.split_pending) begin
                            bus.split_pending <= 1'b1;
                            bus.split_owner   <= bus.grant_idx;
                        end else begin
                            bus.split_err <= 1'b1;
                            rr_ptr        <= ptr_next;
                        end
                    end else if (!bus.init_req[bus.grant_idx]) begin
                        state          <= ARB_IDLE;
                        bus.init_grant <= '0;
                        bus.bus_busy   <= 1'b0;
                        rr_ptr         <= ptr_next;
                    end
                end
                ARB_SPLIT: begin
                    if (bus.target_ack) begin
                        state             <= ARB_IDLE;
                        bus.init_grant    <= '0;
                        bus.split_grant   <= 1'b0;
                        bus.bus_busy      <= 1'b0;
                        bus.split_pending <= 1'b0;
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed and randomized checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;
    import bus_arb_pkg::*;

    localparam int N  = 2;
    localparam int IW = 1;
    localparam int OW = N + 2 * IW + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.NUM_INIT(N), .IDX_W(IW)) bus ();

    bus_arbiter #(.NUM_INIT(N), .IDX_W(IW)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // model: owner -1 means the bus is free; ptr is the index searched first
    int m_owner, m_ptr, m_sowner, m_gidx;
    bit m_split, m_pend, m_err;

    wire [OW-1:0] obs = {bus.init_grant, bus.split_grant, bus.bus_busy, bus.grant_idx,
                         bus.split_pending, bus.split_owner, bus.split_err};

    function automatic void model_reset();
        m_owner = -1; m_ptr = 0; m_sowner = 0; m_gidx = 0;
        m_split = 0; m_pend = 0; m_err = 0;
    endfunction

    function automatic void model_next();
        if (m_owner < 0) begin
            if (m_pend && bus.split_req) begin
                m_owner = m_sowner; m_gidx = m_sowner; m_split = 1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    int j;
                    j = (m_ptr + i) % N;
                    if (m_owner < 0 && bus.init_req[j] && !(m_pend && j == m_sowner)) begin
                        m_owner = j; m_gidx = j;
                    end
                end
            end
        end else if (m_split) begin
            if (bus.target_ack) begin
                m_owner = -1; m_split = 0; m_pend = 0;
            end
        end else if (bus.target_ack) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end else if (bus.target_split_ack) begin
            if (!m_pend) begin
                m_pend = 1; m_sowner = m_owner;
            end else begin
                m_err = 1; m_ptr = (m_owner + 1) % N;
            end
            m_owner = -1;
        end else if (!bus.init_req[m_owner]) begin
            m_ptr = (m_owner + 1) % N; m_owner = -1;
        end
    endfunction

    function automatic logic [OW-1:0] expv();
        logic [N-1:0] g;
        logic [IW-1:0] gi, so;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        gi = IW'(m_gidx);
        so = IW'(m_sowner);
        return {g, m_split, (m_owner >= 0), gi, m_pend, so, m_err};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_next();
        #1;
    endtask

    task automatic set_in(input logic [N-1:0] req, input logic ack, input logic sack, input logic sreq);
        bus.init_req         = req;
        bus.target_ack       = ack;
        bus.target_split_ack = sack;
        bus.split_req        = sreq;
    endtask

    task automatic test_reset();
        set_in('0, 0, 0, 0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_chk++;
        if (obs !== '0) begin
            $display("FAIL reset_outputs: got %b want 0", obs); n_fail++;
        end
        rst_n = 1'b1;
        tick();
        n_chk++;
        if (obs !== expv()) begin
            $display("FAIL reset_idle: got %b want %b", obs, expv()); n_fail++;
        end
    endtask

    task automatic test_round_robin();
        set_in(2'b11, 0, 0, 0);
        tick();
        n_chk++;
        if (bus.init_grant !== 2'b01 || bus.bus_busy !== 1'b1) begin
            $display("FAIL rr_first_grant: got %b busy %b want 01 busy 1", bus.init_grant, bus.bus_busy); n_fail++;
        end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_chk++;
            if (obs !== expv()) begin
                $display("FAIL rr_hold: got %b want %b", obs, expv()); n_fail++;
            end
        end
        bus.target_ack = 1; tick(); bus.target_ack = 0;
        n_chk++;
        if (bus.init_grant !== 2'b00 || bus.bus_busy !== 1'b0) begin
            $display("FAIL rr_turnaround: got %b busy %b want 00 busy 0", bus.init_grant, bus.bus_busy); n_fail++;
        end
        tick();
        n_chk++;
        if (bus.init_grant !== 2'b10 || bus.grant_idx !== 1'b1) begin
            $display("FAIL rr_second_grant: got %b idx %b want 10 idx 1", bus.init_grant, bus.grant_idx); n_fail++;
        end
        bus.target_ack = 1; tick(); set_in('0, 0, 0, 0); tick();
    endtask

    task automatic test_split_park();
        set_in(2'b01, 0, 0, 0);
        tick();
        bus.target_split_ack = 1; tick(); bus.target_split_ack = 0;
        n_chk++;
        if (bus.split_pending !== 1'b1 || bus.split_owner !== 1'b0 || bus.init_grant !== 2'b00) begin
            $display("FAIL split_park: got pend %b owner %b grant %b want 1 0 00",
                     bus.split_pending, bus.split_owner, bus.init_grant); n_fail++;
        end
        bus.init_req = 2'b11;
        tick();
        n_chk++;
        if (bus.init_grant !== 2'b10) begin
            $display("FAIL split_mask: got %b want 10", bus.init_grant); n_fail++;
        end
    endtask

    task automatic test_split_priority();
        bus.split_req = 1;
        tick();
        n_chk++;
        if (bus.split_grant !== 1'b0 || bus.init_grant !== 2'b10) begin
            $display("FAIL split_no_preempt: got sg %b grant %b want 0 10", bus.split_grant, bus.init_grant); n_fail++;
        end
        bus.target_ack = 1; tick(); bus.target_ack = 0;
        n_chk++;
        if (obs !== expv() || bus.bus_busy !== 1'b0) begin
            $display("FAIL split_idle_gap: got %b want %b", obs, expv()); n_fail++;
        end
        tick();
        n_chk++;
        if (bus.split_grant !== 1'b1 || bus.init_grant !== 2'b01) begin
            $display("FAIL split_grant: got sg %b grant %b want 1 01", bus.split_grant, bus.init_grant); n_fail++;
        end
        bus.split_req = 0;
        tick();
        n_chk++;
        if (bus.split_grant !== 1'b1 || bus.init_grant !== 2'b01) begin
            $display("FAIL split_hold: got sg %b grant %b want 1 01", bus.split_grant, bus.init_grant); n_fail++;
        end
        bus.target_ack = 1; tick(); bus.target_ack = 0;
        n_chk++;
        if (bus.split_pending !== 1'b0 || bus.split_grant !== 1'b0 || bus.init_grant !== 2'b00) begin
            $display("FAIL split_done: got pend %b sg %b grant %b want 0 0 00",
                     bus.split_pending, bus.split_grant, bus.init_grant); n_fail++;
        end
        tick();
        bus.target_ack = 1; tick(); set_in('0, 0, 0, 0); tick();
        set_in(2'b01, 0, 0, 0); tick();
        bus.target_split_ack = 1; tick();
        set_in(2'b10, 0, 0, 1);
        tick();
        n_chk++;
        if (bus.split_grant !== 1'b1 || bus.init_grant !== 2'b01) begin
            $display("FAIL split_vs_req: got sg %b grant %b want 1 01", bus.split_grant, bus.init_grant); n_fail++;
        end
        bus.split_req = 0; bus.target_ack = 1; tick(); bus.target_ack = 0;
        tick();
        n_chk++;
        if (bus.init_grant !== 2'b10 || obs !== expv()) begin
            $display("FAIL split_then_req: got %b want %b", obs, expv()); n_fail++;
        end
        bus.target_ack = 1; tick(); set_in('0, 0, 0, 0); tick();
    endtask

    task automatic test_err_abort();
        set_in(2'b01, 0, 0, 0); tick();
        bus.target_split_ack = 1; tick(); bus.target_split_ack = 0;
        bus.init_req = 2'b10; tick();
        bus.target_split_ack = 1; tick(); bus.target_split_ack = 0;
        n_chk++;
        if (bus.split_err !== 1'b1 || bus.split_owner !== 1'b0 || bus.split_pending !== 1'b1 || bus.init_grant !== 2'b00) begin
            $display("FAIL split_err: got err %b owner %b pend %b grant %b want 1 0 1 00",
                     bus.split_err, bus.split_owner, bus.split_pending, bus.init_grant); n_fail++;
        end
        tick();
        bus.init_req = 2'b00; tick();
        n_chk++;
        if (bus.init_grant !== 2'b00 || obs !== expv()) begin
            $display("FAIL abort_release: got %b want %b", obs, expv()); n_fail++;
        end
        bus.split_req = 1; tick(); bus.split_req = 0;
        bus.target_ack = 1; tick(); bus.target_ack = 0;
        bus.init_req = 2'b11; tick();
        bus.init_req = 2'b10; tick();
        n_chk++;
        if (bus.init_grant !== 2'b00) begin
            $display("FAIL abort_owner0: got %b want 00", bus.init_grant); n_fail++;
        end
        tick();
        n_chk++;
        if (bus.init_grant !== 2'b10 || bus.split_err !== 1'b1) begin
            $display("FAIL abort_next: got grant %b err %b want 10 1", bus.init_grant, bus.split_err); n_fail++;
        end
        bus.target_ack = 1; tick(); set_in('0, 0, 0, 0); tick();
    endtask

    task automatic test_async_reset();
        set_in(2'b01, 0, 0, 0); tick();
        bus.target_split_ack = 1; tick();
        set_in(2'b00, 0, 0, 1); tick();
        n_chk++;
        if (bus.split_grant !== 1'b1) begin
            $display("FAIL areset_setup: got sg %b want 1", bus.split_grant); n_fail++;
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if (obs !== '0) begin
            $display("FAIL areset_async: got %b want 0", obs); n_fail++;
        end
        model_reset();
        set_in('0, 0, 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.init_req = 2'b11;
        tick();
        n_chk++;
        if (bus.init_grant !== 2'b01 || bus.split_pending !== 1'b0) begin
            $display("FAIL areset_restart: got grant %b pend %b want 01 0", bus.init_grant, bus.split_pending); n_fail++;
        end
        bus.target_ack = 1; tick(); set_in('0, 0, 0, 0); tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_in(N'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                   ($urandom_range(0, 2) == 0));
            tick();
            n_chk++;
            if (obs !== expv()) begin
                $display("FAIL random_cycle %0d: got %b want %b", c, obs, expv()); n_fail++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_round_robin();
        test_split_park();
        test_split_priority();
        test_err_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Central arbiter for the serial bus. Shares the address/data lines between NUM_INIT initiators, one of which is the bus bridge initiator side.
- Supports one split-capable target, i.e. the bridge target side. When that target issues a split ack, its initiator is parked and the bus is freed for others.
- When the split target later raises split_req, the arbiter gives it the bus (split_grant) ahead of any new request, so the parked transaction can finish.
- Sits between initiator request lines and the bus mux select.

Parameters:
- NUM_INIT, 2, number of initiators; range 2..8.
- IDX_W, $clog2(NUM_INIT) (minimum 1), width of index outputs.

Ports:
- clk  input  1  bus clock
- rst_n  input  1  reset; asynchronous assert, active-low
- init_req  input  NUM_INIT  per-initiator bus request; level, held until transaction ends
- init_grant  output  NUM_INIT  one-hot grant, registered
- grant_idx  output  IDX_W  index of current owner; valid while bus_busy
- bus_busy  output  1  a grant or split_grant is active
- target_ack  input  1  one-cycle pulse: current transaction complete
- target_split_ack  input  1  one-cycle pulse: addressed target has split the transaction
- split_req  input  1  split target is ready to return data; level
- split_grant  output  1  bus granted to split target for completion, registered
- split_pending  output  1  one transaction is parked
- split_owner  output  IDX_W  initiator parked on the split
- split_err  output  1  sticky: split_ack seen while split_pending; cleared only by reset

Behaviour:
- Reset values: all outputs 0; state ARB_IDLE; round-robin pointer 0.
- States:
  - ARB_IDLE:
    - If split_pending and split_req are both high: go to ARB_SPLIT, split_grant<=1, init_grant[split_owner]<=1. The split target wins over every init_req.
    - Otherwise, if any unmasked init_req is high: round-robin pick starting at (last_winner+1) mod NUM_INIT; grant is one-hot; go to ARB_BUSY.
    - Masked means index == split_owner while split_pending.
    - Latency: request sampled in ARB_IDLE, grant visible the next cycle.
  - ARB_BUSY (owner k):
    - target_ack: clear grant, go to ARB_IDLE, last_winner<=k.
    - target_split_ack with !split_pending: split_pending<=1, split_owner<=k, clear grant, go to ARB_IDLE.
    - target_split_ack with split_pending already set: set split_err, treat it as target_ack (release the bus), leave the existing split_owner unchanged.
    - Owner drops init_req with no ack: abort, clear grant, go to ARB_IDLE.
    - If target_ack and target_split_ack arrive in the same cycle, target_ack wins.
  - ARB_SPLIT:
    - Holds split_grant and init_grant[split_owner] until target_ack.
    - On target_ack: clear both grants, split_pending<=0, go to ARB_IDLE.
    - split_req deasserting before target_ack is ignored; the grant is held.
    - init_req from the owner is not required in this state.
- Turnaround: every release passes through ARB_IDLE for at least one cycle with all grants 0. There are no back-to-back grants.
- bus_busy = |init_grant | split_grant, registered alongside the grants.
- grant_idx and split_owner hold their last value when inactive. Consumers qualify them with bus_busy / split_pending.
- The round-robin pointer updates only on a normal ARB_BUSY completion or abort, never on a split completion.
- Async reset mid-transaction drops all grants immediately and clears split state; no recovery of the parked transaction.

Decomposition:
- Package bus_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY, ARB_SPLIT}
  - default NUM_INIT constant
- One combinational sub-module, bus_arb_rr_pick:
  - Inputs: req vector, mask vector, last_winner.
  - Outputs: one-hot winner, winner index, any_valid.
- Reused by later multi-target arbiters.

Test Plan:
- NUM_INIT=2. init_req=2'b11 from reset -> init_grant=01 at cycle 2. target_ack at cycle 5 -> grants 00 for one cycle, then init_grant=10 (round-robin).
- Owner 0 granted, target_split_ack pulse -> next cycle split_pending=1, split_owner=0, grant=00. Held init_req[1] -> init_grant=10. init_req[0] stays masked.
- Split pending and init 1 busy, split_req=1 -> no preemption. After target_ack, one idle cycle, then split_grant=1 and init_grant=01 even though init_req[1] is still high. target_ack -> split_pending=0.
- split_req and init_req[1] rise together in ARB_IDLE with split_pending -> split_grant wins. init 1 is granted only after the split completes.
- Second target_split_ack while split_pending -> split_err=1 (sticky), bus released, split_owner unchanged. Owner drops init_req with no ack -> grant cleared, next requester granted.
- rst_n low while in ARB_SPLIT -> all outputs 0 asynchronously. After release, fresh arbitration starts from index 0.
